// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single unified memory port of the multi-cycle MIPS core between
// the core itself and an external loader/debug master. Requests that meet in
// IDLE are settled by round-robin. A locked external burst may keep priority
// for up to BURST_MAX consecutive grants. Each granted access takes exactly
// one ACC cycle. In that cycle the latched request drives the memory and the
// read data is returned together with the acknowledge.
module mem_port_arbiter #(
  parameter int MEM_WORDS = 64,
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  // core requester
  input  logic        c_req,
  input  logic [31:0] c_addr,
  input  logic        c_we,
  input  logic [31:0] c_wd,
  output logic        c_ack,
  output logic [31:0] c_rd,
  output logic        c_err,
  // external loader/debug requester
  input  logic        e_req,
  input  logic [31:0] e_addr,
  input  logic        e_we,
  input  logic [31:0] e_wd,
  input  logic        e_lock,
  output logic        e_ack,
  output logic [31:0] e_rd,
  output logic        e_err,
  // memory port (combinational read)
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  // Burst counter must be able to hold BURST_MAX itself (saturation value).
  localparam int CW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BURST_LIM = CW'(BURST_MAX);
  localparam logic [31:0]   ADDR_LIM  = 32'(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_C = 2'd1,
    ACC_E = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_grant_c;
  logic            w_grant_e;
  logic            w_lock_win;

  // Last-grant pointer: 1 means the external master was served last.
  logic            r_last_e;
  logic [CW-1:0]   r_burst_cnt;

  // Payload of the access currently being served.
  logic [31:0]     r_addr;
  logic            r_we;
  logic [31:0]     r_wd;

  logic            w_in_range;
  logic            w_acc_c;
  logic            w_acc_e;
  logic            w_acc;

  // Burst count after an external grant: a locked grant counts up and sticks
  // at the limit, while an unlocked grant ends any burst.
  function automatic logic [CW-1:0] burst_after_ext(input logic [CW-1:0] cnt,
                                                    input logic          lock);
    logic [CW-1:0] res;
    if (!lock) begin
      res = '0;
    end else if (cnt >= BURST_LIM) begin
      res = BURST_LIM;
    end else begin
      res = cnt + 1'b1;
    end
    return res;
  endfunction

  // Next-state and grant decision; grants are made only in IDLE.
  always_comb begin
    w_state_nxt = IDLE;
    w_grant_c   = 1'b0;
    w_grant_e   = 1'b0;
    // A locked burst keeps priority only if it already holds the last grant
    // and has not used up its budget.
    w_lock_win  = e_lock && r_last_e && (r_burst_cnt < BURST_LIM);
    unique case (r_state)
      IDLE: begin
        if (c_req && e_req) begin
          if (w_lock_win) begin
            w_grant_e = 1'b1;
          end else if (r_last_e) begin
            w_grant_c = 1'b1;
          end else begin
            w_grant_e = 1'b1;
          end
        end else if (c_req) begin
          w_grant_c = 1'b1;
        end else if (e_req) begin
          w_grant_e = 1'b1;
        end
        if (w_grant_c) begin
          w_state_nxt = ACC_C;
        end else if (w_grant_e) begin
          w_state_nxt = ACC_E;
        end
      end
      ACC_C:   w_state_nxt = IDLE;
      ACC_E:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration history: last-grant pointer and locked-burst counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_e    <= 1'b1;
      r_burst_cnt <= '0;
    end else if (w_grant_c) begin
      r_last_e    <= 1'b0;
      r_burst_cnt <= '0;
    end else if (w_grant_e) begin
      r_last_e    <= 1'b1;
      r_burst_cnt <= burst_after_ext(r_burst_cnt, e_lock);
    end
  end

  // Capture the winner's payload at the grant so that ACC does not depend on
  // the requesters' inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_we   <= 1'b0;
      r_wd   <= '0;
    end else if (w_grant_c) begin
      r_addr <= c_addr;
      r_we   <= c_we;
      r_wd   <= c_wd;
    end else if (w_grant_e) begin
      r_addr <= e_addr;
      r_we   <= e_we;
      r_wd   <= e_wd;
    end
  end

  // Reset gates the access combinationally so an interrupted ACC neither
  // writes nor acknowledges.
  assign w_in_range = (r_addr < ADDR_LIM);
  assign w_acc_c    = (r_state == ACC_C) && !rst;
  assign w_acc_e    = (r_state == ACC_E) && !rst;
  assign w_acc      = w_acc_c || w_acc_e;

  // Memory port and response drive; all outputs idle at zero.
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    c_ack    = 1'b0;
    c_rd     = '0;
    c_err    = 1'b0;
    e_ack    = 1'b0;
    e_rd     = '0;
    e_err    = 1'b0;
    if (w_acc) begin
      mem_addr = w_in_range ? r_addr : 32'd0;
      mem_we   = r_we && w_in_range;
      mem_wd   = r_wd;
    end
    if (w_acc_c) begin
      c_ack = 1'b1;
      c_rd  = w_in_range ? mem_rd : 32'd0;
      c_err = !w_in_range;
    end
    if (w_acc_e) begin
      e_ack = 1'b1;
      e_rd  = w_in_range ? mem_rd : 32'd0;
      e_err = !w_in_range;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic. A transaction-level reference model predicts the grants and
// the memory contents.
module tb_mem_port_arbiter;

  localparam int MW   = 64;
  localparam int BMAX = 4;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, c_ack, c_err;
  logic [31:0] c_addr, c_wd, c_rd;
  logic        e_req, e_we, e_lock, e_ack, e_err;
  logic [31:0] e_addr, e_wd, e_rd;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  mem_port_arbiter #(.MEM_WORDS(MW), .BURST_MAX(BMAX)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_addr(c_addr), .c_we(c_we), .c_wd(c_wd),
    .c_ack(c_ack), .c_rd(c_rd), .c_err(c_err),
    .e_req(e_req), .e_addr(e_addr), .e_we(e_we), .e_wd(e_wd), .e_lock(e_lock),
    .e_ack(e_ack), .e_rd(e_rd), .e_err(e_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the port: combinational read, write on the rising edge.
  logic [31:0] mem [MW];
  logic        mem_init;

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  assign mem_rd = (mem_addr < 32'(MW)) ? mem[mem_addr[5:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MW; i++) mem[i] <= init_word(i);
    end else if (mem_we && (mem_addr < 32'(MW))) begin
      mem[mem_addr[5:0]] <= mem_wd;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [MW];
  bit          m_last_e;
  int          m_burst;

  // Requester intent.
  bit          c_pend, e_pend;
  logic [31:0] c_a, c_d, e_a, e_d;
  bit          c_w, e_w, e_l;

  logic [31:0] obs_rd;
  logic        obs_err;

  int n_chk;
  int n_fail;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive();
    c_req  = c_pend; c_addr = c_a; c_we = c_w; c_wd = c_d;
    e_req  = e_pend; e_addr = e_a; e_we = e_w; e_wd = e_d; e_lock = e_l;
  endtask

  task automatic chk_all_zero(input string tag);
    chk32({tag, "_ctl"}, {27'd0, c_ack, e_ack, c_err, e_err, mem_we}, 32'd0);
    chk32({tag, "_bus"}, mem_addr | mem_wd | c_rd | e_rd, 32'd0);
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at a falling edge
  // with the DUT back in IDLE. who: 0 none, 1 core, 2 external.
  task automatic round(output int who);
    logic [31:0] a, d, exp_rd;
    logic        w, inr;
    drive();
    #1;
    chk_all_zero("idle");
    if (c_pend && e_pend) begin
      if (e_l && m_last_e && (m_burst < BMAX)) who = 2;
      else who = m_last_e ? 1 : 2;
    end else if (c_pend) begin
      who = 1;
    end else if (e_pend) begin
      who = 2;
    end else begin
      who = 0;
    end
    @(posedge clk);
    @(negedge clk);
    if (who == 0) return;
    if (who == 1) begin a = c_a; d = c_d; w = c_w; end
    else          begin a = e_a; d = e_d; w = e_w; end
    inr    = (a < 32'(MW));
    exp_rd = inr ? ref_mem[a[5:0]] : 32'd0;
    #1;
    if (who == 1) begin
      chk1("c_ack", c_ack, 1'b1);
      chk1("e_ack_off", e_ack, 1'b0);
      chk32("c_rd", c_rd, exp_rd);
      chk1("c_err", c_err, !inr);
      chk1("e_err_off", e_err, 1'b0);
      obs_rd = c_rd; obs_err = c_err;
    end else begin
      chk1("e_ack", e_ack, 1'b1);
      chk1("c_ack_off", c_ack, 1'b0);
      chk32("e_rd", e_rd, exp_rd);
      chk1("e_err", e_err, !inr);
      chk1("c_err_off", c_err, 1'b0);
      obs_rd = e_rd; obs_err = e_err;
    end
    chk1("acc_we", mem_we, w && inr);
    chk32("acc_addr", mem_addr, inr ? a : 32'd0);
    if (w && inr) chk32("acc_wd", mem_wd, d);
    if (w && inr) ref_mem[a[5:0]] = d;
    if (who == 1) begin
      m_last_e = 1'b0; m_burst = 0; c_pend = 1'b0;
    end else begin
      m_last_e = 1'b1;
      m_burst  = e_l ? ((m_burst + 1 > BMAX) ? BMAX : m_burst + 1) : 0;
      e_pend   = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge; one reset cycle, returns at a falling edge in IDLE.
  task automatic do_reset();
    rst = 1'b1; c_pend = 1'b0; e_pend = 1'b0;
    drive();
    #1;
    chk_all_zero("rst");
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_all_zero("rst_hold");
    rst = 1'b0;
    m_last_e = 1'b1; m_burst = 0;
  endtask

  int who;
  int seq[$];
  int exp_seq[9];
  int next_a;
  int guard;
  int r;

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; mem_init = 1'b1;
    c_pend = 0; e_pend = 0; c_a = 0; c_d = 0; c_w = 0;
    e_a = 0; e_d = 0; e_w = 0; e_l = 0;
    obs_rd = 0; obs_err = 0;
    drive();
    for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
    m_last_e = 1'b1; m_burst = 0;
    @(negedge clk);
    mem_init = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Core read of word 5.
    c_pend = 1; c_a = 5; c_w = 0; c_d = 0;
    round(who);
    chk32("read5_who", 32'(who), 32'd1);
    chk32("read5_rd", obs_rd, 32'hDEADBEEF);

    // Contention right after reset: C,E,C,E.
    do_reset();
    c_a = 1; c_w = 1; c_d = 32'h11;
    e_a = 2; e_w = 1; e_d = 32'h22; e_l = 0;
    for (int i = 0; i < 4; i++) begin
      c_pend = 1; e_pend = 1;
      round(who);
      chk32("cont_who", 32'(who), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    c_pend = 0; e_pend = 0;
    round(who);
    chk32("cont_mem1", mem[1], 32'h11);
    chk32("cont_mem2", mem[2], 32'h22);

    // Locked burst with the core waiting throughout.
    exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2};
    e_a = 0; e_w = 1; e_d = 32'hB0; e_l = 1; e_pend = 1; c_pend = 0;
    round(who);
    seq.push_back(who);
    next_a = 1;
    c_a = 9; c_w = 0; c_d = 0;
    guard = 0;
    while ((next_a < 8 || e_pend) && guard < 40) begin
      if (!e_pend && next_a < 8) begin
        e_pend = 1; e_a = 32'(next_a); e_d = 32'hB0 + 32'(next_a); next_a++;
      end
      c_pend = 1;
      round(who);
      seq.push_back(who);
      guard++;
    end
    chk32("burst_len", 32'(seq.size()), 32'd9);
    for (int i = 0; i < 9 && i < seq.size(); i++) chk32("burst_who", 32'(seq[i]), 32'(exp_seq[i]));
    round(who);
    chk32("burst_tail_who", 32'(who), 32'd1);
    e_l = 0;

    // Out-of-range core write.
    c_pend = 1; c_a = 64; c_w = 1; c_d = 32'hFFFFFFFF;
    round(who);
    chk32("oor_who", 32'(who), 32'd1);
    chk1("oor_err", obs_err, 1'b1);
    chk32("oor_mem0", mem[0], ref_mem[0]);

    // Reset during an external write access.
    c_pend = 0; e_pend = 1; e_a = 10; e_w = 1; e_d = 32'hCAFEF00D; e_l = 0;
    drive();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("rmid_e_ack", e_ack, 1'b0);
    chk1("rmid_we", mem_we, 1'b0);
    chk1("rmid_c_ack", c_ack, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk32("rmid_mem10", mem[10], ref_mem[10]);
    rst = 1'b0;
    m_last_e = 1'b1; m_burst = 0;
    c_pend = 1; c_a = 10; c_w = 0; c_d = 0;
    round(who);
    chk32("rmid_first_who", 32'(who), 32'd1);
    round(who);
    chk32("rmid_second_who", 32'(who), 32'd2);

    // Back-to-back core accesses to word 3.
    c_pend = 1; c_a = 3; c_w = 0;
    round(who);
    c_pend = 1; c_a = 3; c_w = 1; c_d = 32'hA5;
    round(who);
    c_pend = 1; c_a = 3; c_w = 0; c_d = 0;
    round(who);
    chk32("b2b_rd", obs_rd, 32'h0000_00A5);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      if (!c_pend && ($urandom_range(0, 3) != 0)) begin
        c_pend = 1; c_w = 1'($urandom_range(0, 1)); c_d = $urandom;
        r = $urandom_range(0, 9);
        if (r == 0)      c_a = 32'(MW) + $urandom_range(0, 200);
        else if (r == 1) c_a = $urandom;
        else             c_a = $urandom_range(0, MW - 1);
      end
      if (!e_pend && ($urandom_range(0, 3) != 0)) begin
        e_pend = 1; e_w = 1'($urandom_range(0, 1)); e_d = $urandom;
        e_l = ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 9);
        if (r == 0) e_a = 32'(MW) + $urandom_range(0, 200);
        else        e_a = $urandom_range(0, MW - 1);
      end
      round(who);
    end
    c_pend = 0; e_pend = 0;
    round(who);

    for (int i = 0; i < MW; i++) chk32("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
